// File: rtl/exa_crosb_output_arbiter_with_vcs_if.sv
// rtl/exa_crosb_output_arbiter_with_vcs_if.sv - request/grant and credit bundle of one crossbar output arbiter
interface exa_crosb_output_arbiter_with_vcs_if #(
  parameter int INPUT_NUM = 4,
  parameter int PRIO_NUM  = 2,
  parameter int VC_NUM    = 2
);
  localparam int NV     = PRIO_NUM * VC_NUM;
  localparam int LOG_VP = (NV > 1) ? $clog2(NV) : 1;
  localparam int LOG_IN = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;

  logic [INPUT_NUM-1:0][NV-1:0] i_request;
  logic                         i_valid;
  logic                         i_last;
  logic [NV-1:0]                i_credit_return;
  logic [INPUT_NUM-1:0]         o_grant;
  logic [LOG_VP-1:0]            o_grant_vc;
  logic [LOG_IN-1:0]            o_grant_input;
  logic [NV-1:0]                o_credits;
  logic                         o_busy;
  logic                         o_credit_err;

  modport master (
    output i_request, i_valid, i_last, i_credit_return,
    input  o_grant, o_grant_vc, o_grant_input, o_credits, o_busy, o_credit_err
  );

  modport slave (
    input  i_request, i_valid, i_last, i_credit_return,
    output o_grant, o_grant_vc, o_grant_input, o_credits, o_busy, o_credit_err
  );
endinterface

// File: rtl/exa_crosb_output_arbiter_with_vcs.sv
// rtl/exa_crosb_output_arbiter_with_vcs.sv - per-output arbiter: strict priority, per-priority round-robin, per-VC credits
module exa_crosb_output_arbiter_with_vcs #(
  parameter int INPUT_NUM  = 4,
  parameter int PRIO_NUM   = 2,
  parameter int VC_NUM     = 2,
  parameter int CREDIT_MAX = 8,
  parameter int PKT_WORDS  = 4
) (
  input logic clk,
  input logic resetn,
  exa_crosb_output_arbiter_with_vcs_if.slave io_arb
);
  localparam int NV     = PRIO_NUM * VC_NUM;
  localparam int NC     = INPUT_NUM * VC_NUM;
  localparam int LOG_VP = (NV > 1) ? $clog2(NV) : 1;
  localparam int LOG_IN = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
  localparam int LOG_C  = (NC > 1) ? $clog2(NC) : 1;
  localparam int LOG_P  = (PRIO_NUM > 1) ? $clog2(PRIO_NUM) : 1;
  localparam int CW     = $clog2(CREDIT_MAX + 1);

  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_load;
  logic                 w_clear;

  logic [INPUT_NUM-1:0] r_grant;
  logic [LOG_VP-1:0]    r_grant_vc;
  logic [LOG_IN-1:0]    r_grant_input;
  logic [NV-1:0]        r_credits;
  logic                 r_credit_err;
  logic [LOG_C-1:0]     r_rr_ptr [PRIO_NUM];
  logic [CW-1:0]        r_cnt [NV];

  logic                 w_found;
  logic [LOG_P-1:0]     w_win_prio;
  logic [LOG_VP-1:0]    w_win_vc;
  logic [LOG_IN-1:0]    w_win_input;
  logic [LOG_C-1:0]     w_win_ptr_nxt;

  logic [CW-1:0]        w_cnt_nxt [NV];
  logic [NV-1:0]        w_dec;
  logic [NV-1:0]        w_credits_nxt;
  logic                 w_err_set;

  // Priorities scanned low to high so the highest level with a candidate overrides
  always_comb begin : arb_comb
    int   idx;
    int   pc;
    logic pfound;
    w_found       = 1'b0;
    w_win_prio    = '0;
    w_win_vc      = '0;
    w_win_input   = '0;
    w_win_ptr_nxt = '0;
    idx           = 0;
    pc            = 0;
    pfound        = 1'b0;
    for (int p = 0; p < PRIO_NUM; p++) begin
      pfound = 1'b0;
      pc     = 0;
      for (int k = 0; k < NC; k++) begin
        idx = int'(r_rr_ptr[p]) + k;
        if (idx >= NC) idx = idx - NC;
        if (!pfound && io_arb.i_request[idx / VC_NUM][p * VC_NUM + idx % VC_NUM]
                    && r_credits[p * VC_NUM + idx % VC_NUM]) begin
          pfound = 1'b1;
          pc     = idx;
        end
      end
      if (pfound) begin
        w_found       = 1'b1;
        w_win_prio    = LOG_P'(p);
        w_win_vc      = LOG_VP'(p * VC_NUM + pc % VC_NUM);
        w_win_input   = LOG_IN'(pc / VC_NUM);
        w_win_ptr_nxt = LOG_C'((pc + 1) % NC);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANTED;
          w_load      = 1'b1;
        end
      end
      GRANTED: begin
        if (io_arb.i_valid && io_arb.i_last) begin
          w_state_nxt = IDLE;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Simultaneous return and consume cancel; saturation flags an accounting error
  always_comb begin
    w_err_set     = 1'b0;
    w_dec         = '0;
    w_credits_nxt = '0;
    for (int v = 0; v < NV; v++) begin
      w_cnt_nxt[v] = r_cnt[v];
      w_dec[v]     = io_arb.i_valid && (r_state == GRANTED) && (r_grant_vc == LOG_VP'(v));
      if (w_dec[v] && !io_arb.i_credit_return[v]) begin
        if (r_cnt[v] == '0) w_err_set = 1'b1;
        else                w_cnt_nxt[v] = r_cnt[v] - CW'(1);
      end else if (io_arb.i_credit_return[v] && !w_dec[v]) begin
        if (r_cnt[v] == CW'(CREDIT_MAX)) w_err_set = 1'b1;
        else                             w_cnt_nxt[v] = r_cnt[v] + CW'(1);
      end
      w_credits_nxt[v] = (w_cnt_nxt[v] >= CW'(PKT_WORDS));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_grant       <= '0;
      r_grant_vc    <= '0;
      r_grant_input <= '0;
      r_credits     <= '1;
      r_credit_err  <= 1'b0;
      for (int p = 0; p < PRIO_NUM; p++) r_rr_ptr[p] <= '0;
      for (int v = 0; v < NV; v++)       r_cnt[v]    <= CW'(CREDIT_MAX);
    end else begin
      if (w_load) begin
        r_grant                <= INPUT_NUM'(1) << w_win_input;
        r_grant_vc             <= w_win_vc;
        r_grant_input          <= w_win_input;
        r_rr_ptr[w_win_prio]   <= w_win_ptr_nxt;
      end else if (w_clear) begin
        r_grant       <= '0;
        r_grant_vc    <= '0;
        r_grant_input <= '0;
      end
      for (int v = 0; v < NV; v++) r_cnt[v] <= w_cnt_nxt[v];
      r_credits <= w_credits_nxt;
      if (w_err_set) r_credit_err <= 1'b1;
    end
  end

  assign io_arb.o_grant       = r_grant;
  assign io_arb.o_grant_vc    = r_grant_vc;
  assign io_arb.o_grant_input = r_grant_input;
  assign io_arb.o_credits     = r_credits;
  assign io_arb.o_busy        = (r_state == GRANTED);
  assign io_arb.o_credit_err  = r_credit_err;
endmodule

// File: tb/tb_exa_crosb_output_arbiter_with_vcs.sv
// tb/tb_exa_crosb_output_arbiter_with_vcs.sv - directed bench for the output arbiter with VCs
module tb_exa_crosb_output_arbiter_with_vcs;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;
  int   exp_rr [4] = '{0, 3, 0, 3};

  always #5 clk = ~clk;

  exa_crosb_output_arbiter_with_vcs_if #(.INPUT_NUM(4), .PRIO_NUM(2), .VC_NUM(2)) u_if ();

  exa_crosb_output_arbiter_with_vcs #(
    .INPUT_NUM(4), .PRIO_NUM(2), .VC_NUM(2), .CREDIT_MAX(8), .PKT_WORDS(4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .io_arb (u_if)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int cnt(input int v);
    return int'(dut.r_cnt[v]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.i_request       = '0;
    u_if.i_valid         = 1'b0;
    u_if.i_last          = 1'b0;
    u_if.i_credit_return = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic word(input logic last);
    u_if.i_valid = 1'b1;
    u_if.i_last  = last;
    step();
    u_if.i_valid = 1'b0;
    u_if.i_last  = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_grant", int'(u_if.o_grant), 0);
    check("rst_vc", int'(u_if.o_grant_vc), 0);
    check("rst_input", int'(u_if.o_grant_input), 0);
    check("rst_busy", int'(u_if.o_busy), 0);
    check("rst_err", int'(u_if.o_credit_err), 0);
    check("rst_credits", int'(u_if.o_credits), 15);
    check("rst_cnt1", cnt(1), 8);

    // Input 2 on VC1, four-word packet
    u_if.i_request[2][1] = 1'b1;
    step();
    u_if.i_request = '0;
    check("t1_grant", int'(u_if.o_grant), 4);
    check("t1_vc", int'(u_if.o_grant_vc), 1);
    check("t1_input", int'(u_if.o_grant_input), 2);
    check("t1_busy", int'(u_if.o_busy), 1);
    for (int w = 0; w < 4; w++) begin
      word(w == 3);
      if (w < 3) check("t1_hold", int'(u_if.o_grant), 4);
    end
    check("t1_drop", int'(u_if.o_grant), 0);
    check("t1_idle", int'(u_if.o_busy), 0);
    check("t1_cnt1", cnt(1), 4);
    check("t1_credits", int'(u_if.o_credits), 15);

    // Priority then round-robin within prio 0
    do_reset();
    u_if.i_request[0][0] = 1'b1;
    u_if.i_request[3][0] = 1'b1;
    u_if.i_request[1][2] = 1'b1;
    step();
    u_if.i_request[1][2] = 1'b0;
    check("t2_hi_grant", int'(u_if.o_grant), 2);
    check("t2_hi_vc", int'(u_if.o_grant_vc), 2);
    word(1'b1);
    check("t2_bubble", int'(u_if.o_grant), 0);
    for (int pk = 0; pk < 4; pk++) begin
      step();
      check("t2_rr_input", int'(u_if.o_grant_input), exp_rr[pk]);
      check("t2_rr_vc", int'(u_if.o_grant_vc), 0);
      word(1'b1);
      check("t2_rr_bubble", int'(u_if.o_grant), 0);
    end
    u_if.i_request = '0;
    check("t2_cnt0", cnt(0), 4);
    check("t2_cnt2", cnt(2), 7);

    // Credit starvation on VC3
    do_reset();
    u_if.i_request[0][3] = 1'b1;
    step();
    u_if.i_request = '0;
    check("t3_grant", int'(u_if.o_grant), 1);
    check("t3_vc", int'(u_if.o_grant_vc), 3);
    for (int w = 0; w < 5; w++) word(w == 4);
    check("t3_cnt3", cnt(3), 3);
    check("t3_credits_low", int'(u_if.o_credits), 7);
    u_if.i_request[1][3] = 1'b1;
    step();
    check("t3_blocked_a", int'(u_if.o_grant), 0);
    step();
    check("t3_blocked_b", int'(u_if.o_grant), 0);
    u_if.i_credit_return = 4'b1000;
    step();
    u_if.i_credit_return = '0;
    check("t3_credits_back", int'(u_if.o_credits), 15);
    check("t3_not_yet", int'(u_if.o_grant), 0);
    step();
    check("t3_late_grant", int'(u_if.o_grant), 2);
    check("t3_late_vc", int'(u_if.o_grant_vc), 3);
    u_if.i_request = '0;
    word(1'b1);

    // Consume and return on the same VC in one cycle
    do_reset();
    u_if.i_request[2][0] = 1'b1;
    step();
    u_if.i_request = '0;
    check("t4_grant", int'(u_if.o_grant), 4);
    u_if.i_credit_return = 4'b0001;
    word(1'b0);
    u_if.i_credit_return = '0;
    check("t4_cnt0_same", cnt(0), 8);
    check("t4_no_err", int'(u_if.o_credit_err), 0);
    check("t4_busy", int'(u_if.o_busy), 1);
    word(1'b1);
    check("t4_cnt0_dec", cnt(0), 7);
    check("t4_done", int'(u_if.o_grant), 0);

    // Overflow: nine returns at full credit
    do_reset();
    u_if.i_credit_return = 4'b0100;
    repeat (9) step();
    u_if.i_credit_return = '0;
    check("t5_cnt2", cnt(2), 8);
    check("t5_err", int'(u_if.o_credit_err), 1);
    repeat (3) step();
    check("t5_err_sticky", int'(u_if.o_credit_err), 1);
    resetn = 1'b0;
    #1;
    check("t5_err_clr", int'(u_if.o_credit_err), 0);

    // Asynchronous reset mid-packet
    do_reset();
    u_if.i_request[1][1] = 1'b1;
    step();
    u_if.i_request = '0;
    check("t6_grant", int'(u_if.o_grant), 2);
    for (int w = 0; w < 3; w++) word(1'b0);
    check("t6_cnt1", cnt(1), 5);
    check("t6_busy", int'(u_if.o_busy), 1);
    u_if.i_request[0][1] = 1'b1;
    u_if.i_request[2][1] = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    check("t6_async_grant", int'(u_if.o_grant), 0);
    check("t6_async_busy", int'(u_if.o_busy), 0);
    check("t6_async_cnt1", cnt(1), 8);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step();
    check("t6_after_grant", int'(u_if.o_grant), 1);
    check("t6_after_input", int'(u_if.o_grant_input), 0);
    check("t6_after_vc", int'(u_if.o_grant_vc), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
